// File: rtl/sweep_controller_pkg.sv
// -----------------------------------------------------------------------------
// tracker_pkg
// Shared definitions for the solar tracker's max-voltage search.
//   ADC_W    : width of an ADC conversion result
//   CMP_LSB  : lowest bit taken into the "is it larger" comparison; the bits
//              below it are treated as noise, as in the tracker comparator
//   ST_*     : sweep_controller state encoding (also seen on the STATE
//              debug output)
//   cmp_gt() : strict unsigned compare on the [ADC_W-1:CMP_LSB] slice
// -----------------------------------------------------------------------------
package tracker_pkg;

   localparam int ADC_W   = 12;
   localparam int CMP_LSB = 4;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_MOVE     = 3'd1;
   localparam logic [2:0] ST_SETTLE   = 3'd2;
   localparam logic [2:0] ST_SAMPLE   = 3'd3;
   localparam logic [2:0] ST_WAIT_ADC = 3'd4;
   localparam logic [2:0] ST_UPDATE   = 3'd5;
   localparam logic [2:0] ST_RETURN   = 3'd6;
   localparam logic [2:0] ST_FINISH   = 3'd7;

   function automatic logic cmp_gt(input logic [ADC_W-1:0] a,
                                   input logic [ADC_W-1:0] b);
      return a[ADC_W-1:CMP_LSB] > b[ADC_W-1:CMP_LSB];
   endfunction

endpackage

// File: rtl/sweep_controller_if.sv
// -----------------------------------------------------------------------------
// sweep_controller_if
// Bundles the sweep controller's control, ADC and servo signals.
//   START      : one-cycle sweep request from top-level control
//   ADC_START  : one-cycle conversion request to the ADC interface
//   ADC_VALID  : one-cycle strobe, ADC_DATA valid
//   ADC_DATA   : conversion result
//   POS        : servo position command
//   BEST_POS   : position of the largest reading so far
//   BEST_VAL   : full reading at BEST_POS
//   BUSY/DONE/ERR : status (ERR = sticky ADC timeout)
//   STATE      : FSM state, debug visibility only
// Handshake: ADC_START is a single-cycle request; the ADC answers with a
// single-cycle ADC_VALID no earlier than the cycle after ADC_START, and the
// controller only accepts it while waiting for a conversion (there is no
// ready/back-pressure; an unexpected strobe is simply dropped).
// master = controller side, slave = environment side.
// -----------------------------------------------------------------------------
interface sweep_controller_if #(
   parameter int POS_W = 8
);
   logic                           START;
   logic                           ADC_START;
   logic                           ADC_VALID;
   logic [tracker_pkg::ADC_W-1:0]  ADC_DATA;
   logic [POS_W-1:0]               POS;
   logic [POS_W-1:0]               BEST_POS;
   logic [tracker_pkg::ADC_W-1:0]  BEST_VAL;
   logic                           BUSY;
   logic                           DONE;
   logic                           ERR;
   logic [2:0]                     STATE;

   modport master (
      input  START, ADC_VALID, ADC_DATA,
      output ADC_START, POS, BEST_POS, BEST_VAL, BUSY, DONE, ERR, STATE
   );

   modport slave (
      output START, ADC_VALID, ADC_DATA,
      input  ADC_START, POS, BEST_POS, BEST_VAL, BUSY, DONE, ERR, STATE
   );
endinterface

// File: rtl/sweep_controller_timer.sv
// -----------------------------------------------------------------------------
// sweep_timer
// Loadable down-counter with a zero flag. After a load it decrements once per
// cycle and parks at zero.
//   CLK, RST  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val this cycle (takes priority over counting)
//   load_val  : value to load
//   zero      : count is zero
// -----------------------------------------------------------------------------
module sweep_timer #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/sweep_controller.sv
// -----------------------------------------------------------------------------
// sweep_controller
// Steps the servo over 0, STEP, 2*STEP ... <= POS_MAX, settles, takes one ADC
// conversion per position and keeps the largest (8-MSB compare) reading and
// its position, then returns the servo to that position and pulses DONE.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : sweep_controller_if.master (START, ADC handshake, POS, BEST_*,
//              BUSY, DONE, ERR, STATE debug)
// All bus outputs are registered.
// -----------------------------------------------------------------------------
module sweep_controller
   import tracker_pkg::*;
#(
   parameter int POS_W         = 8,
   parameter int POS_MAX       = 180,
   parameter int STEP          = 1,
   parameter int SETTLE_CYCLES = 100000,
   parameter int ADC_TIMEOUT   = 4096
) (
   input logic               CLK,
   input logic               RST,
   sweep_controller_if.master bus
);
   localparam int CNT_MAX = (SETTLE_CYCLES > ADC_TIMEOUT) ? SETTLE_CYCLES : ADC_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LOAD    = CNT_W'(ADC_TIMEOUT - 1);
   // One extra bit so POS + STEP cannot wrap before the range check.
   localparam logic [POS_W:0]   POS_MAX_X   = (POS_W+1)'(POS_MAX);
   localparam logic [POS_W:0]   STEP_X      = (POS_W+1)'(STEP);

   logic [2:0]       state, state_n;
   logic [POS_W-1:0] pos, best_pos;
   logic [ADC_W-1:0] best_val, sample;
   logic             sample_ok;
   logic             adc_start, busy, done, err;
   logic             settle_load, tmo_load, settle_zero, tmo_zero;
   logic [POS_W:0]   pos_next;
   logic             more, take;

   sweep_timer #(.W(CNT_W)) u_settle (
      .CLK(CLK), .RST(RST), .load(settle_load), .load_val(SETTLE_LOAD), .zero(settle_zero)
   );

   sweep_timer #(.W(CNT_W)) u_timeout (
      .CLK(CLK), .RST(RST), .load(tmo_load), .load_val(TMO_LOAD), .zero(tmo_zero)
   );

   assign pos_next = {1'b0, pos} + STEP_X;
   assign more     = (pos_next <= POS_MAX_X);
   // A timed-out conversion leaves sample_ok low and can never win.
   assign take     = sample_ok && cmp_gt(sample, best_val);

   always_comb begin
      state_n     = state;
      settle_load = 1'b0;
      tmo_load    = 1'b0;
      case (state)
         ST_IDLE:     if (bus.START) state_n = ST_MOVE;
         ST_MOVE:     begin settle_load = 1'b1; state_n = ST_SETTLE; end
         ST_SETTLE:   if (settle_zero) state_n = ST_SAMPLE;
         ST_SAMPLE:   begin tmo_load = 1'b1; state_n = ST_WAIT_ADC; end
         // The strobe wins over an expiring timeout in the same cycle.
         ST_WAIT_ADC: if (bus.ADC_VALID || tmo_zero) state_n = ST_UPDATE;
         ST_UPDATE: begin
            if (more) begin
               state_n = ST_MOVE;
            end else begin
               // Servo is commanded back here, so its settle starts now.
               settle_load = 1'b1;
               state_n     = ST_RETURN;
            end
         end
         ST_RETURN:   if (settle_zero) state_n = ST_FINISH;
         ST_FINISH:   state_n = ST_IDLE;
         default:     state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         pos       <= '0;
         best_pos  <= '0;
         best_val  <= '0;
         sample    <= '0;
         sample_ok <= 1'b0;
         adc_start <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         busy      <= (state_n != ST_IDLE);
         adc_start <= (state == ST_SETTLE) && settle_zero;
         done      <= (state == ST_RETURN) && settle_zero;
         case (state)
            ST_IDLE: begin
               if (bus.START) begin
                  pos      <= '0;
                  best_pos <= '0;
                  best_val <= '0;
                  err      <= 1'b0;
               end
            end
            ST_WAIT_ADC: begin
               if (bus.ADC_VALID) begin
                  sample    <= bus.ADC_DATA;
                  sample_ok <= 1'b1;
               end else if (tmo_zero) begin
                  sample_ok <= 1'b0;
                  err       <= 1'b1;
               end
            end
            ST_UPDATE: begin
               if (take) begin
                  best_pos <= pos;
                  best_val <= sample;
               end
               if (more) begin
                  pos <= pos_next[POS_W-1:0];
               end else begin
                  pos <= take ? pos : best_pos;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.ADC_START = adc_start;
   assign bus.POS       = pos;
   assign bus.BEST_POS  = best_pos;
   assign bus.BEST_VAL  = best_val;
   assign bus.BUSY      = busy;
   assign bus.DONE      = done;
   assign bus.ERR       = err;
   assign bus.STATE     = state;
endmodule

// File: tb/tb_sweep_controller.sv
// -----------------------------------------------------------------------------
// tb_sweep_controller
// Two controllers: A (POS_MAX=4, STEP=1) and B (POS_MAX=5, STEP=2), both with
// SETTLE_CYCLES=3 and ADC_TIMEOUT=8. A shared ADC responder answers whichever
// one is selected from a per-position table (reading, reply delay, no-reply).
// The reference model derives the sampled positions and the winner straight
// from the table; a compare process checks outputs every cycle against it.
// -----------------------------------------------------------------------------
module tb_sweep_controller;
   import tracker_pkg::*;

   localparam int POS_W  = 8;
   localparam int SETTLE = 3;
   localparam int TMO    = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sweep_controller_if #(.POS_W(POS_W)) bus_a ();
   sweep_controller_if #(.POS_W(POS_W)) bus_b ();

   sweep_controller #(.POS_W(POS_W), .POS_MAX(4), .STEP(1),
      .SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(TMO)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
   sweep_controller #(.POS_W(POS_W), .POS_MAX(5), .STEP(2),
      .SETTLE_CYCLES(SETTLE), .ADC_TIMEOUT(TMO)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

   // ---------------- stimulus variables and muxing ----------------
   logic             sel;            // 0 = A active, 1 = B active
   logic             start;
   logic             adc_valid;
   logic [ADC_W-1:0] adc_data;
   int               cfg_pmax, cfg_step;
   int               spur_req, spur_ack;
   logic [ADC_W-1:0] rd   [0:7];
   int               dly  [0:7];
   logic             miss [0:7];

   assign bus_a.START     = start & ~sel;
   assign bus_b.START     = start & sel;
   assign bus_a.ADC_VALID = adc_valid & ~sel;
   assign bus_b.ADC_VALID = adc_valid & sel;
   assign bus_a.ADC_DATA  = adc_data;
   assign bus_b.ADC_DATA  = adc_data;

   logic             m_adc_start, m_busy, m_done, m_err;
   logic [POS_W-1:0] m_pos, m_best_pos;
   logic [ADC_W-1:0] m_best_val;
   logic [2:0]       m_state;
   assign m_adc_start = sel ? bus_b.ADC_START : bus_a.ADC_START;
   assign m_busy      = sel ? bus_b.BUSY      : bus_a.BUSY;
   assign m_done      = sel ? bus_b.DONE      : bus_a.DONE;
   assign m_err       = sel ? bus_b.ERR       : bus_a.ERR;
   assign m_pos       = sel ? bus_b.POS       : bus_a.POS;
   assign m_best_pos  = sel ? bus_b.BEST_POS  : bus_a.BEST_POS;
   assign m_best_val  = sel ? bus_b.BEST_VAL  : bus_a.BEST_VAL;
   assign m_state     = sel ? bus_b.STATE     : bus_a.STATE;

   // ---------------- scoreboard ----------------
   int               checks = 0;
   int               errors = 0;
   logic [POS_W-1:0] exp_q[$];
   int               exp_bp, exp_bv;
   logic             exp_err;
   int               starts_seen, done_seen;
   logic             prev_busy, prev_start, prev_done, in_sweep;
   logic [ADC_W-1:0] prev_best;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Expected outcome of one sweep straight from the reply table.
   task automatic compute_model(input int pmax, input int step);
      exp_q.delete();
      exp_bp  = 0;
      exp_bv  = 0;
      exp_err = 1'b0;
      for (int p = 0; p <= pmax; p += step) begin
         exp_q.push_back(POS_W'(p));
         if (!miss[p] && dly[p] >= 1 && dly[p] <= TMO) begin
            if ((int'(rd[p]) / 16) > (exp_bv / 16)) begin
               exp_bp = p;
               exp_bv = int'(rd[p]);
            end
         end else begin
            exp_err = 1'b1;
         end
      end
   endtask

   initial begin : compare
      prev_busy = 0; prev_start = 0; prev_done = 0; in_sweep = 0; prev_best = '0;
      starts_seen = 0; done_seen = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_q.delete();
            prev_busy = 0; prev_start = 0; prev_done = 0; in_sweep = 0; prev_best = '0;
         end else begin
            if (m_busy && !prev_busy) begin
               compute_model(cfg_pmax, cfg_step);
               in_sweep = 1; starts_seen = 0; done_seen = 0;
            end
            if (m_busy) begin
               chk("pos_in_range", 32'(m_pos <= POS_W'(cfg_pmax)), 1);
               if (prev_busy)
                  chk("best_monotonic", 32'(m_best_val[11:4] >= prev_best[11:4]), 1);
            end
            if (in_sweep && !m_done) chk("busy_in_sweep", m_busy, 1);
            if (m_adc_start) begin
               starts_seen++;
               chk("adc_start_width", prev_start, 0);
               chk("sample_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) chk("sample_pos", m_pos, exp_q.pop_front());
            end
            if (m_done) begin
               done_seen++;
               chk("done_width", prev_done, 0);
               chk("done_once", done_seen, 1);
               chk("done_all_sampled", exp_q.size(), 0);
               chk("done_best_pos", m_best_pos, exp_bp);
               chk("done_best_val", m_best_val, exp_bv);
               chk("done_pos", m_pos, exp_bp);
               chk("done_err", m_err, exp_err);
               in_sweep = 0;
            end
            prev_busy = m_busy; prev_start = m_adc_start; prev_done = m_done;
            prev_best = m_best_val;
         end
      end
   end

   // ---------------- ADC responder ----------------
   initial begin : responder
      int p, d;
      adc_valid = 0; adc_data = '0; spur_ack = 0;
      forever begin
         @(posedge clk); #2;
         adc_valid = 0;
         if (!rst && m_adc_start && !miss[m_pos]) begin
            p = int'(m_pos);
            d = dly[p];
            repeat (d) begin @(posedge clk); #2; end
            adc_valid = 1;
            adc_data  = rd[p];
         end else if (!rst && spur_req != spur_ack && m_state == ST_SETTLE) begin
            spur_ack  = spur_req;
            adc_valid = 1;
            adc_data  = 12'hFFF;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic set_tbl(input logic [ADC_W-1:0] v0, v1, v2, v3, v4);
      for (int i = 0; i < 8; i++) begin dly[i] = 2; miss[i] = 0; rd[i] = '0; end
      rd[0] = v0; rd[1] = v1; rd[2] = v2; rd[3] = v3; rd[4] = v4;
   endtask

   // START in cycle t; returns in cycle t+1 having checked BUSY/MOVE/ERR.
   task automatic start_sweep();
      step();
      start = 1;
      step();
      start = 0;
      chk("start_busy", m_busy, 1);
      chk("start_state_move", m_state, ST_MOVE);
      chk("start_err_clear", m_err, 0);
   endtask

   task automatic wait_sample_at(input int p, output int n);
      logic ok = 0;
      n = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (m_adc_start && m_pos == POS_W'(p)) ok = 1;
         else begin step(); n++; end
      end
      chk("sample_seen_in_budget", ok, 1);
   endtask

   task automatic wait_state_pos(input logic [2:0] st, input int p);
      logic ok = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (m_state == st && m_pos == POS_W'(p)) ok = 1;
         else step();
      end
      chk("state_seen_in_budget", ok, 1);
   endtask

   task automatic wait_done();
      logic ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
         step();
         if (m_done) ok = 1;
      end
      chk("done_in_budget", ok, 1);
   endtask

   task automatic after_done();
      step();
      chk("post_done_busy", m_busy, 0);
      chk("post_done_done", m_done, 0);
      chk("post_done_idle", m_state, ST_IDLE);
      repeat (5) step();
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      logic [ADC_W-1:0] bv;
      logic [POS_W-1:0] bp;
      rst = 1; start = 0; sel = 0; cfg_pmax = 4; cfg_step = 1; spur_req = 0;
      set_tbl(12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
      repeat (3) step();
      chk("rst_pos", bus_a.POS, 0);
      chk("rst_best_pos", bus_a.BEST_POS, 0);
      chk("rst_best_val", bus_a.BEST_VAL, 0);
      chk("rst_adc_start", bus_a.ADC_START, 0);
      chk("rst_busy", bus_a.BUSY, 0);
      chk("rst_done", bus_a.DONE, 0);
      chk("rst_err", bus_a.ERR, 0);
      chk("rst_state", bus_a.STATE, ST_IDLE);
      chk("rst_b_busy", bus_b.BUSY, 0);
      rst = 0;
      repeat (2) step();

      // Single peak, plus first-sample and update latency.
      set_tbl(12'h100, 12'h250, 12'h7F0, 12'h300, 12'h050);
      start_sweep();
      wait_sample_at(0, n);
      chk("adc_start_latency", n, SETTLE + 1);
      repeat (3) step();
      chk("update_state", m_state, ST_UPDATE);
      chk("update_pos_held", m_pos, 0);
      step();
      chk("advance_pos", m_pos, 1);
      chk("advance_best_val", m_best_val, 12'h100);
      chk("advance_state_move", m_state, ST_MOVE);
      wait_done();
      chk("peak_best_pos", m_best_pos, 2);
      chk("peak_best_val", m_best_val, 12'h7F0);
      chk("peak_pos", m_pos, 2);
      chk("peak_err", m_err, 0);
      after_done();

      // LSB-only tie, with a spurious START and ADC_VALID during SETTLE.
      set_tbl(12'h40A, 12'h40F, 12'h200, 12'h3F0, 12'h030);
      start_sweep();
      wait_sample_at(0, n);
      wait_state_pos(ST_SETTLE, 1);
      bv = m_best_val; bp = m_best_pos;
      start = 1; spur_req++;
      step();
      start = 0;
      chk("spur_state1", m_state, ST_SETTLE);
      step();
      chk("spur_state2", m_state, ST_SETTLE);
      chk("spur_best_val", m_best_val, bv);
      chk("spur_best_pos", m_best_pos, bp);
      wait_done();
      chk("tie_best_pos", m_best_pos, 0);
      chk("tie_best_val", m_best_val, 12'h40A);
      after_done();

      // Timeout at POS 3; POS 4 answers in the last timeout cycle.
      set_tbl(12'h120, 12'h340, 12'h220, 12'hFF0, 12'h600);
      miss[3] = 1; dly[4] = TMO;
      start_sweep();
      wait_sample_at(3, n);
      repeat (TMO) step();
      chk("tmo_err_before", m_err, 0);
      chk("tmo_state_wait", m_state, ST_WAIT_ADC);
      step();
      chk("tmo_err_set", m_err, 1);
      chk("tmo_state_update", m_state, ST_UPDATE);
      wait_done();
      chk("tmo_best_pos", m_best_pos, 4);
      chk("tmo_best_val", m_best_val, 12'h600);
      chk("tmo_err_final", m_err, 1);
      after_done();

      // Reply in the same cycle as ADC_START is not accepted.
      set_tbl(12'h100, 12'hF00, 12'h200, 12'h300, 12'h050);
      dly[1] = 0;
      start_sweep();
      wait_done();
      chk("same_cycle_best_pos", m_best_pos, 3);
      chk("same_cycle_best_val", m_best_val, 12'h300);
      chk("same_cycle_err", m_err, 1);
      after_done();

      // Reset during WAIT_ADC at POS 2, then a clean sweep.
      set_tbl(12'h100, 12'h250, 12'h7F0, 12'h300, 12'h050);
      start_sweep();
      wait_state_pos(ST_WAIT_ADC, 2);
      #2 rst = 1;
      #1;
      chk("arst_pos", m_pos, 0);
      chk("arst_best_pos", m_best_pos, 0);
      chk("arst_best_val", m_best_val, 0);
      chk("arst_busy", m_busy, 0);
      chk("arst_done", m_done, 0);
      chk("arst_err", m_err, 0);
      chk("arst_adc_start", m_adc_start, 0);
      chk("arst_state", m_state, ST_IDLE);
      repeat (3) step();
      rst = 0;
      repeat (10) step();
      chk("arst_no_done", m_done, 0);
      start_sweep();
      wait_done();
      chk("rerun_best_pos", m_best_pos, 2);
      chk("rerun_best_val", m_best_val, 12'h7F0);
      after_done();

      // STEP=2, POS_MAX=5: samples at 0, 2, 4 only.
      sel = 1; cfg_pmax = 5; cfg_step = 2;
      set_tbl(12'h100, 12'hFFF, 12'h500, 12'hFFF, 12'h300);
      repeat (2) step();
      start_sweep();
      wait_sample_at(0, n);
      chk("b_adc_start_latency", n, SETTLE + 1);
      wait_done();
      chk("b_adc_starts", starts_seen, 3);
      chk("b_best_pos", m_best_pos, 2);
      chk("b_best_val", m_best_val, 12'h500);
      after_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached, got no summary expected summary");
      $fatal(1);
   end
endmodule
